reg_access_arbiter: RTL and testbench

REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

---
 rtl/reg_access_arbiter.sv | 178 +++++++++++++++++
 tb/tb_reg_access_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_access_arbiter.sv
// Two-requester round-robin arbiter in front of a simple register block.
// Each access runs IDLE -> SETUP -> ACCESS [-> CAPTURE] -> DONE.
module reg_access_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = 4'hF
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] reg_address,
  output logic              reg_write_en,
  output logic              reg_read_en,
  output logic [DATA_W-1:0] reg_data_in,
  input  logic [DATA_W-1:0] reg_read_data
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    CAPTURE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              busy_q, busy_d;

  logic pick;

  // Contention goes to whoever was not granted last.
  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      (req0 & req1):  pick = ~last_q;
      (req1 & ~req0): pick = 1'b1;
      (req0 & ~req1): pick = 1'b0;
      default:        pick = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    raddr_d = IDLE_ADDR;
    we_d    = 1'b0;
    re_d    = 1'b0;
    din_d   = '0;
    rdata_d = rdata_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          gnt_d   = pick;
          last_d  = pick;
          wr_d    = pick ? wr1 : wr0;
          addr_d  = pick ? addr1 : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          raddr_d = pick ? addr1 : addr0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        raddr_d = addr_q;
        we_d    = wr_q;
        re_d    = ~wr_q;
        din_d   = wr_q ? wdata_q : '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (wr_q) begin
          done0_d = ~gnt_q;
          done1_d = gnt_q;
          state_d = DONE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        rdata_d = reg_read_data;
        done0_d = ~gnt_q;
        done1_d = gnt_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= IDLE_ADDR;
      wdata_q <= '0;
      raddr_q <= IDLE_ADDR;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      din_q   <= '0;
      rdata_q <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      raddr_q <= raddr_d;
      we_q    <= we_d;
      re_q    <= re_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
    end
  end

  assign reg_address  = raddr_q;
  assign reg_write_en = we_q;
  assign reg_read_en  = re_q;
  assign reg_data_in  = din_q;
  assign rdata        = rdata_q;
  assign done0        = done0_q;
  assign done1        = done1_q;
  assign busy         = busy_q;

  a_strobe_excl: assert property (
    @(posedge clk) disable iff (resetb)
    !(we_q && re_q)
  );

  a_done_excl: assert property (
    @(posedge clk) disable iff (resetb)
    !(done0_q && done1_q)
  );

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Scoreboard bench for reg_access_arbiter.
// Expected transactions are queued at stimulus time and checked at strobe/done.
module tb_reg_access_arbiter;

  logic       clk = 1'b0;
  logic       resetb = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       wr0 = 1'b0, wr1 = 1'b0;
  logic [3:0] addr0 = 4'h0, addr1 = 4'h0;
  logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
  logic       done0, done1, busy;
  logic [7:0] rdata;
  logic [3:0] reg_address;
  logic       reg_write_en, reg_read_en;
  logic [7:0] reg_data_in;
  logic [7:0] reg_read_data = 8'h00;

  always #5 clk = ~clk;

  reg_access_arbiter dut (
    .clk          (clk),
    .resetb       (resetb),
    .req0         (req0),
    .req1         (req1),
    .wr0          (wr0),
    .wr1          (wr1),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .done0        (done0),
    .done1        (done1),
    .rdata        (rdata),
    .busy         (busy),
    .reg_address  (reg_address),
    .reg_write_en (reg_write_en),
    .reg_read_en  (reg_read_en),
    .reg_data_in  (reg_data_in),
    .reg_read_data(reg_read_data)
  );

  // register block model
  logic [7:0] mem [16] = '{default: 8'h00};
  always @(posedge clk) begin
    if (reg_write_en) mem[reg_address] <= reg_data_in;
    if (reg_read_en) reg_read_data <= mem[reg_address];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic       id;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
  } txn_t;

  typedef struct {
    txn_t t;
    int   due;
  } pend_t;

  txn_t  exp_q[$];
  pend_t dq[$];
  logic [7:0] ref_mem [16] = '{default: 8'h00};
  logic [7:0] last_rd = 8'h00;
  int cyc = 0;
  int start = 0;
  logic busy_p = 1'b0;

  function automatic txn_t mk(input logic id, input logic wr,
                              input logic [3:0] a, input logic [7:0] d);
    txn_t x;
    x.id = id;
    x.wr = wr;
    x.addr = a;
    x.data = d;
    return x;
  endfunction

  initial begin
    txn_t  t;
    pend_t p;
    forever begin
      @(negedge clk);
      cyc++;
      if (resetb) begin
        busy_p = 1'b0;
        continue;
      end
      if (busy && !busy_p) start = cyc;
      busy_p = busy;
      if (reg_write_en || reg_read_en) begin
        check("strobe_excl", 32'(reg_write_en & reg_read_en), 0);
        check("strobe_busy", 32'(busy), 1);
        if (exp_q.size() == 0) begin
          check("strobe_unexp", 1, 0);
        end else begin
          t = exp_q.pop_front();
          check("strobe_cyc", cyc - start, 1);
          check("strobe_we", 32'(reg_write_en), 32'(t.wr));
          check("strobe_addr", 32'(reg_address), 32'(t.addr));
          check("strobe_din", 32'(reg_data_in), t.wr ? 32'(t.data) : 0);
          if (!t.wr) t.data = ref_mem[t.addr];
          p.t = t;
          p.due = start + (t.wr ? 2 : 3);
          dq.push_back(p);
        end
      end
      if (done0 || done1) begin
        check("done_excl", 32'(done0 & done1), 0);
        check("done_busy", 32'(busy), 1);
        if (dq.size() == 0) begin
          check("done_unexp", 1, 0);
        end else begin
          p = dq.pop_front();
          check("done_id", 32'(done1), 32'(p.t.id));
          check("done_cyc", cyc, p.due);
          if (p.t.wr) begin
            ref_mem[p.t.addr] = p.t.data;
            check("rdata_hold", 32'(rdata), 32'(last_rd));
          end else begin
            check("rdata", 32'(rdata), 32'(p.t.data));
            last_rd = p.t.data;
          end
        end
      end
      if (!busy) begin
        check("idle_addr", 32'(reg_address), 32'hF);
        check("idle_din", 32'(reg_data_in), 0);
      end
    end
  end

  task automatic drive(input logic id, input logic wr, input logic [3:0] a,
                       input logic [7:0] d, input int n);
    int got = 0;
    @(negedge clk);
    if (id) begin
      wr1 = wr; addr1 = a; wdata1 = d; req1 = 1'b1;
    end else begin
      wr0 = wr; addr0 = a; wdata0 = d; req0 = 1'b1;
    end
    for (int k = 0; k < 80 && got < n; k++) begin
      @(negedge clk);
      if ((id ? done1 : done0) === 1'b1) got++;
    end
    check(id ? "drive1_done" : "drive0_done", got, n);
    @(posedge clk);
    #1;
    if (id) req1 = 1'b0;
    else req0 = 1'b0;
  endtask

  task automatic scramble();
    int seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    check("scr_busy_seen", seen, 1);
    addr1 = 4'h9; wr1 = 1'b1; wdata1 = 8'hFF;
    addr0 = 4'h7; wr0 = 1'b1; wdata0 = 8'hEE;
  endtask

  initial begin
    int seen;
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(reg_address), 32'hF);
    check("rst_din", 32'(reg_data_in), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_we", 32'(reg_write_en), 0);
    check("rst_re", 32'(reg_read_en), 0);
    check("rst_done0", 32'(done0), 0);
    check("rst_done1", 32'(done1), 0);
    check("rst_busy", 32'(busy), 0);
    resetb = 1'b0;

    // contention from reset release: 0,1,0,1
    exp_q.push_back(mk(1'b0, 1'b1, 4'h1, 8'hA6));
    exp_q.push_back(mk(1'b1, 1'b1, 4'h2, 8'hA7));
    exp_q.push_back(mk(1'b0, 1'b1, 4'h1, 8'hA6));
    exp_q.push_back(mk(1'b1, 1'b1, 4'h2, 8'hA7));
    fork
      drive(1'b0, 1'b1, 4'h1, 8'hA6, 2);
      drive(1'b1, 1'b1, 4'h2, 8'hA7, 2);
    join

    exp_q.push_back(mk(1'b0, 1'b1, 4'h0, 8'hA5));
    drive(1'b0, 1'b1, 4'h0, 8'hA5, 1);
    exp_q.push_back(mk(1'b0, 1'b0, 4'h0, 8'h00));
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1);

    exp_q.push_back(mk(1'b1, 1'b1, 4'h3, 8'h3C));
    drive(1'b1, 1'b1, 4'h3, 8'h3C, 1);
    exp_q.push_back(mk(1'b1, 1'b0, 4'h3, 8'h00));
    fork
      drive(1'b1, 1'b0, 4'h3, 8'h00, 1);
      scramble();
    join
    exp_q.push_back(mk(1'b1, 1'b1, 4'h4, 8'h44));
    drive(1'b1, 1'b1, 4'h4, 8'h44, 1);

    // reset in the middle of a write strobe
    exp_q.push_back(mk(1'b0, 1'b1, 4'h5, 8'h5A));
    @(negedge clk);
    wr0 = 1'b1; addr0 = 4'h5; wdata0 = 8'h5A; req0 = 1'b1;
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      @(negedge clk);
      if (reg_write_en) seen = 1;
    end
    check("abort_strobe_seen", seen, 1);
    #2 resetb = 1'b1;
    #1;
    check("abort_we", 32'(reg_write_en), 0);
    check("abort_re", 32'(reg_read_en), 0);
    check("abort_addr", 32'(reg_address), 32'hF);
    check("abort_busy", 32'(busy), 0);
    check("abort_done0", 32'(done0), 0);
    req0 = 1'b0;
    dq.delete();
    last_rd = 8'h00;
    @(negedge clk);
    resetb = 1'b0;
    repeat (8) @(negedge clk);

    exp_q.push_back(mk(1'b0, 1'b0, 4'h5, 8'h00));
    drive(1'b0, 1'b0, 4'h5, 8'h00, 1);
    exp_q.push_back(mk(1'b1, 1'b1, 4'h5, 8'h77));
    drive(1'b1, 1'b1, 4'h5, 8'h77, 1);
    exp_q.push_back(mk(1'b0, 1'b0, 4'h5, 8'h00));
    drive(1'b0, 1'b0, 4'h5, 8'h00, 1);

    repeat (5) @(negedge clk);
    check("drain", exp_q.size() + dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
